// File: rtl/arith_pkg.sv
// Shared constants and select encodings for the arithmetic magnitude datapath.
// Machine numbering: bit 1 is the MSB, bit WORD_W the LSB, and bit 0 is the
// guard bit that sits above B's MSB.
package arith_pkg;

    localparam int WORD_W    = 30;
    localparam int MSB_IDX   = 1;
    localparam int LSB_IDX   = 30;
    localparam int GUARD_IDX = 0;

    // Machine bit number -> vector index. Vectors are [WORD_W-1:0] for A/C and
    // [WORD_W:0] for B, so the guard bit (machine bit 0) lands on index WORD_W.
    function automatic int vec_pos(input int word_w, input int machine_idx);
        return word_w - machine_idx;
    endfunction

    // Next-value source for A, in descending priority.
    typedef enum logic [1:0] {
        A_HOLD,
        A_CLEAR,
        A_MOVE_C,
        A_NOT
    } a_sel_e;

    // Next-value source for B, in descending priority.
    typedef enum logic [2:0] {
        B_HOLD,
        B_CLEAR,
        B_MOVE_C,
        B_SUM,
        B_NOT,
        B_SHL,
        B_SHR
    } b_sel_e;

    // Next-value source for C, in descending priority.
    typedef enum logic [3:0] {
        C_HOLD,
        C_CLEAR,
        C_MOVE_B,
        C_AND,
        C_MEM,
        C_ARR,
        C_SHL,
        C_SHR,
        C_SET30
    } c_sel_e;

endpackage

// File: rtl/arith_if.sv
// Command/flag bus between the program sequencer (master) and the magnitude
// datapath (slave).
interface arith_if #(
    parameter int WORD_W = arith_pkg::WORD_W
);

    // Single-cycle command pulses from the sequencer
    logic              do_clear_a;
    logic              do_clear_b;
    logic              do_clear_c;
    logic              do_not_a;
    logic              do_not_b;
    logic              do_sum;
    logic              do_and;
    logic              do_set_c_30;
    logic              do_left_shift_b;
    logic              do_left_shift_c;
    logic              do_left_shift_c29;
    logic              do_right_shift_bc;
    logic              do_move_c_to_a;
    logic              do_move_c_to_b;
    logic              do_move_b_to_c;
    logic              do_mem_to_c;
    logic              do_arr_c;

    // Data entering the datapath
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] pnl_c_data;
    logic              shift_in_io;

    // Level flags and data leaving the datapath
    logic              carry_out;
    logic              reg_c1;
    logic              reg_c30;
    logic              reg_b0;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] reg_c_to_pnl;
    logic              serial_out_io;

    modport master (
        output do_clear_a, do_clear_b, do_clear_c, do_not_a, do_not_b,
               do_sum, do_and, do_set_c_30, do_left_shift_b, do_left_shift_c,
               do_left_shift_c29, do_right_shift_bc, do_move_c_to_a,
               do_move_c_to_b, do_move_b_to_c, do_mem_to_c, do_arr_c,
               mem_rdata, pnl_c_data, shift_in_io,
        input  carry_out, reg_c1, reg_c30, reg_b0, mem_wdata, reg_c_to_pnl,
               serial_out_io
    );

    modport slave (
        input  do_clear_a, do_clear_b, do_clear_c, do_not_a, do_not_b,
               do_sum, do_and, do_set_c_30, do_left_shift_b, do_left_shift_c,
               do_left_shift_c29, do_right_shift_bc, do_move_c_to_a,
               do_move_c_to_b, do_move_b_to_c, do_mem_to_c, do_arr_c,
               mem_rdata, pnl_c_data, shift_in_io,
        output carry_out, reg_c1, reg_c30, reg_b0, mem_wdata, reg_c_to_pnl,
               serial_out_io
    );

endinterface

// File: rtl/arith_adder.sv
// Combinational one's-complement adder with end-around carry.
// The end carry is reported before being folded back in, because the
// sequencer branches on it in the same cycle it decides to add.
module arith_adder #(
    parameter int WORD_W = arith_pkg::WORD_W
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum,
    output logic              carry
);

    logic [WORD_W:0] w_raw;

    assign w_raw = {1'b0, a} + {1'b0, b};
    assign carry = w_raw[WORD_W];
    // End-around carry; the wrap past 2^WORD_W is intentionally discarded.
    assign sum   = w_raw[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, carry};

endmodule

// File: rtl/arith_unit.sv
// Magnitude datapath: registers A, C and guarded B, the one's-complement
// adder and the shift network. Executes the sequencer's single-cycle pulses
// and exposes the level flags it branches on. Sign bits live in the sequencer.
module arith_unit #(
    parameter int WORD_W = arith_pkg::WORD_W
) (
    input  logic    clk,
    input  logic    reset,
    arith_if.slave  bus
);

    import arith_pkg::*;

    // Vector positions of the architecturally named bits.
    localparam int C1_POS  = vec_pos(WORD_W, MSB_IDX);
    localparam int C29_POS = vec_pos(WORD_W, WORD_W - 1);
    localparam int C30_POS = vec_pos(WORD_W, WORD_W);
    localparam int B0_POS  = vec_pos(WORD_W, GUARD_IDX);

    // A and C are WORD_W bits; B carries the guard bit b0 at index WORD_W.
    logic [WORD_W-1:0] r_a;
    logic [WORD_W:0]   r_b;
    logic [WORD_W-1:0] r_c;

    logic [WORD_W-1:0] w_b_mag;
    logic [WORD_W-1:0] w_sum;
    logic              w_carry;
    logic              w_c1;

    a_sel_e            w_a_sel;
    b_sel_e            w_b_sel;
    c_sel_e            w_c_sel;

    logic [WORD_W-1:0] w_a_next;
    logic [WORD_W:0]   w_b_next;
    logic [WORD_W-1:0] w_c_next;

    assign w_b_mag = r_b[WORD_W-1:0];
    assign w_c1    = r_c[C1_POS];

    arith_adder #(
        .WORD_W (WORD_W)
    ) u_adder (
        .a     (r_a),
        .b     (w_b_mag),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // Priority-encode the pulses into one source per register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_a_sel = A_HOLD;
        w_b_sel = B_HOLD;
        w_c_sel = C_HOLD;

        if (bus.do_clear_a)          w_a_sel = A_CLEAR;
        else if (bus.do_move_c_to_a) w_a_sel = A_MOVE_C;
        else if (bus.do_not_a)       w_a_sel = A_NOT;

        if (bus.do_clear_b)             w_b_sel = B_CLEAR;
        else if (bus.do_move_c_to_b)    w_b_sel = B_MOVE_C;
        else if (bus.do_sum)            w_b_sel = B_SUM;
        else if (bus.do_not_b)          w_b_sel = B_NOT;
        else if (bus.do_left_shift_b)   w_b_sel = B_SHL;
        else if (bus.do_right_shift_bc) w_b_sel = B_SHR;

        if (bus.do_clear_c)             w_c_sel = C_CLEAR;
        else if (bus.do_move_b_to_c)    w_c_sel = C_MOVE_B;
        else if (bus.do_and)            w_c_sel = C_AND;
        else if (bus.do_mem_to_c)       w_c_sel = C_MEM;
        else if (bus.do_arr_c)          w_c_sel = C_ARR;
        else if (bus.do_left_shift_c)   w_c_sel = C_SHL;
        else if (bus.do_right_shift_bc) w_c_sel = C_SHR;
        else if (bus.do_set_c_30)       w_c_sel = C_SET30;
    end

    // Next value of A.
    always_comb begin
        w_a_next = r_a;
        case (w_a_sel)
            A_CLEAR:  w_a_next = '0;
            A_MOVE_C: w_a_next = r_c;
            A_NOT:    w_a_next = ~r_a;
            default:  w_a_next = r_a;
        endcase
    end

    // Next value of B including the guard bit.
    always_comb begin
        w_b_next = r_b;
        case (w_b_sel)
            B_CLEAR:  w_b_next = '0;
            B_MOVE_C: w_b_next = {1'b0, r_c};
            // End carry toggles the guard bit, tracking overflow of the sum.
            B_SUM:    w_b_next = {r_b[B0_POS] ^ w_carry, w_sum};
            // Only the magnitude is complemented; b0 is left as is.
            B_NOT:    w_b_next = {r_b[B0_POS], ~w_b_mag};
            // Whole 31-bit B moves toward b0; c1 enters at b30.
            B_SHL:    w_b_next = {r_b[WORD_W-1:0], w_c1};
            // b30 leaves into c1 (handled on the C side); b0 refills with 0.
            B_SHR:    w_b_next = {1'b0, r_b[WORD_W:1]};
            default:  w_b_next = r_b;
        endcase
    end

    // Next value of C.
    always_comb begin
        w_c_next = r_c;
        case (w_c_sel)
            C_CLEAR:  w_c_next = '0;
            C_MOVE_B: w_c_next = w_b_mag;
            C_AND:    w_c_next = r_a & w_b_mag;
            C_MEM:    w_c_next = bus.mem_rdata;
            C_ARR:    w_c_next = bus.pnl_c_data;
            C_SHL: begin
                w_c_next = {r_c[WORD_W-2:0], bus.shift_in_io};
                // Digit boundary for 4-bit I/O transfers.
                if (bus.do_left_shift_c29) w_c_next[C29_POS] = 1'b0;
                // Division: the quotient bit rides in with the shift.
                if (bus.do_set_c_30)       w_c_next[C30_POS] = 1'b1;
            end
            C_SHR:    w_c_next = {r_b[0], r_c[WORD_W-1:1]};
            C_SET30: begin
                w_c_next          = r_c;
                w_c_next[C30_POS] = 1'b1;
            end
            default:  w_c_next = r_c;
        endcase
    end

    // Register update; reset overrides every pulse in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all moves read pre-edge values (B<->C swaps work).
        if (reset) begin
            // NOTE: there is no RAM here; every register is explicitly reset.
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
            r_c <= w_c_next;
        end
    end

    assign bus.carry_out     = w_carry;
    assign bus.reg_c1        = w_c1;
    assign bus.reg_c30       = r_c[C30_POS];
    assign bus.reg_b0        = r_b[B0_POS];
    assign bus.mem_wdata     = r_c;
    assign bus.reg_c_to_pnl  = r_c;
    assign bus.serial_out_io = w_c1;

endmodule
